// File: rtl/knn_vote_pkg.sv
// Shared definitions for the KNN majority-vote stage: default sizes, derived
// widths and the controller state encoding.
package knn_vote_pkg;

   // Index width that stays at least one bit wide for single-entry tables.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int W_DEF         = 32;
   localparam int HW_K_DEF      = 10;
   localparam int N_CLASSES_DEF = 16;
   localparam int LW_DEF        = W_DEF / 4;
   localparam int CW_DEF        = $clog2(HW_K_DEF + 1);
   localparam int CIW_DEF       = idx_width(N_CLASSES_DEF);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_READ,
      ST_SCAN,
      ST_DONE
   } state_e;

endpackage

// File: rtl/knn_vote_counter_bank.sv
// Per-class vote counters with a synchronous clear, one saturating increment
// port and one combinational read port.
module vote_counter_bank
   import knn_vote_pkg::*;
#(
   parameter int N_CLASSES = N_CLASSES_DEF,
   parameter int HW_K      = HW_K_DEF,
   parameter int CW        = CW_DEF,
   parameter int CIW       = CIW_DEF
) (
   input  logic           clk,
   input  logic           clear_i,
   input  logic           inc_en_i,
   input  logic [CIW-1:0] inc_idx_i,
   input  logic [CIW-1:0] rd_idx_i,
   output logic [CW-1:0]  rd_count_o
);

   logic [CW-1:0] count_q [N_CLASSES];

   // NOTE: the counter array has no reset; the controller clears it at the start of every run.
   always_ff @(posedge clk) begin
      if (clear_i) begin
         for (int c = 0; c < N_CLASSES; c++) count_q[c] <= '0;
      end else if (inc_en_i && (count_q[inc_idx_i] < CW'(HW_K))) begin
         count_q[inc_idx_i] <= count_q[inc_idx_i] + CW'(1);
      end
   end

   assign rd_count_o = count_q[rd_idx_i];

endmodule

// File: rtl/knn_vote.sv
// Majority-vote controller: reads K sorter slots, tallies class labels and
// scans the tallies for the winner (ties go to the lowest class).
module knn_vote
   import knn_vote_pkg::*;
#(
   parameter int  W         = W_DEF,
   parameter int  HW_K      = HW_K_DEF,
   parameter int  N_CLASSES = N_CLASSES_DEF,
   localparam int LW        = W / 4,
   localparam int CW        = $clog2(HW_K + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          START,
   input  logic [15:0]   K,
   output logic [15:0]   SEL,
   input  logic [LW-1:0] LABEL_IN,
   output logic [LW-1:0] LABEL_OUT,
   output logic [CW-1:0] VOTES,
   output logic          READY,
   output logic          BUSY,
   output logic          BAD_LABEL
);

   localparam int CIW = idx_width(N_CLASSES);

   state_e        state_q, state_d;
   logic [CW-1:0] k_eff_q, k_eff_d;
   logic [CW-1:0] i_q, i_d;
   logic [CW-1:0] sel_q, sel_d;
   logic [CIW-1:0] scan_q, scan_d;
   logic [LW-1:0] best_label_q, best_label_d;
   logic [CW-1:0] best_count_q, best_count_d;
   logic [LW-1:0] label_out_q, label_out_d;
   logic [CW-1:0] votes_q, votes_d;
   logic          bad_q, bad_d;

   logic          bank_clear;
   logic          bank_inc_en;
   logic [CW-1:0] bank_rd_count;
   logic          label_ok;

   assign label_ok = (LABEL_IN < LW'(N_CLASSES));

   vote_counter_bank #(
      .N_CLASSES (N_CLASSES),
      .HW_K      (HW_K),
      .CW        (CW),
      .CIW       (CIW)
   ) u_bank (
      .clk        (clk),
      .clear_i    (bank_clear),
      .inc_en_i   (bank_inc_en),
      .inc_idx_i  (LABEL_IN[CIW-1:0]),
      .rd_idx_i   (scan_q),
      .rd_count_o (bank_rd_count)
   );

   // NOTE: every signal driven here gets a default first so no latch is inferred.
   always_comb begin
      state_d      = state_q;
      k_eff_d      = k_eff_q;
      i_d          = i_q;
      sel_d        = sel_q;
      scan_d       = scan_q;
      best_label_d = best_label_q;
      best_count_d = best_count_q;
      label_out_d  = label_out_q;
      votes_d      = votes_q;
      bad_d        = bad_q;
      bank_clear   = 1'b0;
      bank_inc_en  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (START) begin
               k_eff_d = (K > 16'(HW_K)) ? CW'(HW_K) : CW'(K);
               bad_d   = 1'b0;
               state_d = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            bank_clear   = 1'b1;
            i_d          = '0;
            sel_d        = '0;
            scan_d       = '0;
            best_label_d = '0;
            best_count_d = '0;
            state_d      = ST_READ;
         end
         ST_READ: begin
            // LABEL_IN answers the slot selected one cycle earlier.
            if (i_q != '0) begin
               if (label_ok) bank_inc_en = 1'b1;
               else          bad_d       = 1'b1;
            end
            if (i_q == k_eff_q) begin
               state_d = ST_SCAN;
            end else begin
               i_d = i_q + CW'(1);
               if ((i_q + CW'(1)) < k_eff_q) sel_d = i_q + CW'(1);
            end
         end
         ST_SCAN: begin
            if (bank_rd_count > best_count_q) begin
               best_label_d = LW'(scan_q);
               best_count_d = bank_rd_count;
            end
            if (scan_q == CIW'(N_CLASSES - 1)) begin
               label_out_d = best_label_d;
               votes_d     = best_count_d;
               state_d     = ST_DONE;
            end else begin
               scan_d = scan_q + CIW'(1);
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state is written only with non-blocking assignments.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         k_eff_q      <= '0;
         i_q          <= '0;
         sel_q        <= '0;
         scan_q       <= '0;
         best_label_q <= '0;
         best_count_q <= '0;
         label_out_q  <= '0;
         votes_q      <= '0;
         bad_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         k_eff_q      <= k_eff_d;
         i_q          <= i_d;
         sel_q        <= sel_d;
         scan_q       <= scan_d;
         best_label_q <= best_label_d;
         best_count_q <= best_count_d;
         label_out_q  <= label_out_d;
         votes_q      <= votes_d;
         bad_q        <= bad_d;
      end
   end

   assign SEL       = 16'(sel_q);
   assign LABEL_OUT = label_out_q;
   assign VOTES     = votes_q;
   assign READY     = (state_q == ST_DONE);
   assign BUSY      = (state_q != ST_IDLE);
   assign BAD_LABEL = bad_q;

endmodule
